// File: rtl/nn_pkg.sv
// Shared types for the neuron datapath: sample width, signed sample type,
// and the layer sequencer state encoding.
package nn_pkg;

   localparam int DATA_W = 16;

   typedef logic signed [DATA_W-1:0] data_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      WAIT    = 3'd2,
      CAPTURE = 3'd3,
      NEXT    = 3'd4,
      DONE    = 3'd5
   } seq_state_e;

endpackage

// File: rtl/layer_sequencer_argmax.sv
// argmax_tracker: running maximum over the output-buffer write stream.
// A strictly-greater compare keeps the lowest index on ties.
module argmax_tracker
   import nn_pkg::*;
#(
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] idx,
   input  data_t            data,
   output logic [IDX_W-1:0] argmax
);

   localparam data_t MAX_INIT = data_t'(-32768);

   data_t max_val;
   logic  take;

   assign take = wr_en && (data > max_val);

   always_ff @(posedge clk) begin
      if (rst)        argmax <= '0;
      else if (clear) argmax <= '0;
      else if (take)  argmax <= idx;
   end

   // Running maximum is datapath only; every run begins with a clear.
   always_ff @(posedge clk) begin
      if (clear)     max_val <= MAX_INIT;
      else if (take) max_val <= data;
   end

endmodule

// File: rtl/layer_sequencer.sv
// Walks a dense layer one neuron at a time and captures each result.
// Optional argmax reporting is built when SEQ_ARGMAX_EN is defined.
module layer_sequencer
   import nn_pkg::*;
#(
   parameter int NUM_NEURONS = 10,
   parameter int INPUT_SIZE  = 784,
   parameter int TIMEOUT     = INPUT_SIZE + 16,
   localparam int IDX_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             layer_start,
   output logic             layer_busy,
   output logic             layer_done,
   output logic [IDX_W-1:0] neuron_sel,
   output logic             neuron_start,
   input  logic             neuron_done,
   input  data_t            neuron_result,
   output logic             out_wr_en,
   output logic [IDX_W-1:0] out_wr_addr,
   output data_t            out_wr_data,
   output logic             timeout_err
`ifdef SEQ_ARGMAX_EN
   ,
   output logic [IDX_W-1:0] argmax,
   output logic             argmax_valid
`endif
);

   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NEURONS - 1);

   seq_state_e       state, state_nx;
   logic [IDX_W-1:0] idx, idx_nx;
   logic [WD_W-1:0]  wdog, wdog_nx;
   logic             run_clr;
   logic             to_set;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         idx         <= '0;
         wdog        <= '0;
         timeout_err <= 1'b0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
         wdog  <= wdog_nx;
         if (to_set)       timeout_err <= 1'b1;
         else if (run_clr) timeout_err <= 1'b0;
      end
   end

   always_comb begin
      state_nx     = state;
      idx_nx       = idx;
      wdog_nx      = wdog;
      run_clr      = 1'b0;
      to_set       = 1'b0;
      neuron_start = 1'b0;
      layer_done   = 1'b0;
      out_wr_en    = 1'b0;
      out_wr_data  = '0;
      unique case (state)
         IDLE: begin
            if (layer_start) begin
               idx_nx   = '0;
               run_clr  = 1'b1;
               state_nx = START;
            end
         end
         START: begin
            neuron_start = 1'b1;
            wdog_nx      = '0;
            state_nx     = WAIT;
         end
         WAIT: begin
            if (neuron_done) begin
               state_nx = CAPTURE;
            end else if (wdog == WD_LAST) begin
               // Hung neuron: record a zero result so the layer still completes.
               to_set    = 1'b1;
               out_wr_en = 1'b1;
               state_nx  = NEXT;
            end else begin
               wdog_nx = wdog + 1'b1;
            end
         end
         CAPTURE: begin
            out_wr_en   = 1'b1;
            out_wr_data = neuron_result;
            state_nx    = NEXT;
         end
         NEXT: begin
            if (idx == IDX_LAST) begin
               state_nx = DONE;
            end else begin
               idx_nx   = idx + 1'b1;
               state_nx = START;
            end
         end
         DONE: begin
            layer_done = 1'b1;
            state_nx   = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign layer_busy  = (state != IDLE);
   assign neuron_sel  = idx;
   assign out_wr_addr = idx;

`ifdef SEQ_ARGMAX_EN
   argmax_tracker #(
      .IDX_W (IDX_W)
   ) u_argmax (
      .clk    (clk),
      .rst    (rst),
      .clear  (run_clr),
      .wr_en  (out_wr_en),
      .idx    (idx),
      .data   (out_wr_data),
      .argmax (argmax)
   );

   assign argmax_valid = (state == DONE);
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with a behavioural neuron (or hung stub).
// Cycle 0 is the cycle in which layer_start is sampled in IDLE.
module tb_layer_sequencer;
   import nn_pkg::*;

   localparam int NN    = 3;
   localparam int IS    = 4;
   localparam int P     = IS + 5;
   localparam int TO    = IS + 16;
   localparam int IDX_W = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             layer_start = 1'b0;
   logic             layer_busy, layer_done, neuron_start, neuron_done;
   logic [IDX_W-1:0] neuron_sel, out_wr_addr;
   data_t            neuron_result = '0;
   logic             out_wr_en;
   data_t            out_wr_data;
   logic             timeout_err;
   logic [IDX_W-1:0] argmax_s = '0;
   logic             argmax_valid_s = 1'b0;
`ifdef SEQ_ARGMAX_EN
   logic [IDX_W-1:0] argmax;
   logic             argmax_valid;
   assign argmax_s       = argmax;
   assign argmax_valid_s = argmax_valid;
`endif

   layer_sequencer #(
      .NUM_NEURONS (NN),
      .INPUT_SIZE  (IS)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .layer_start   (layer_start),
      .layer_busy    (layer_busy),
      .layer_done    (layer_done),
      .neuron_sel    (neuron_sel),
      .neuron_start  (neuron_start),
      .neuron_done   (neuron_done),
      .neuron_result (neuron_result),
      .out_wr_en     (out_wr_en),
      .out_wr_addr   (out_wr_addr),
      .out_wr_data   (out_wr_data),
      .timeout_err   (timeout_err)
`ifdef SEQ_ARGMAX_EN
      ,
      .argmax        (argmax),
      .argmax_valid  (argmax_valid)
`endif
   );

   always #5 clk = ~clk;

   // Neuron model: done in cycle IS+2 after its start, result valid from IS+3.
   data_t            res [NN];
   logic             stub = 1'b0;
   int               k = 0;
   logic [IDX_W-1:0] nidx = '0;

   always @(posedge clk) begin
      if (neuron_start && !stub) begin
         k    <= 1;
         nidx <= neuron_sel;
      end else if (k != 0 && k < 200) begin
         k <= k + 1;
      end
      if (k == IS + 2) neuron_result <= res[nidx];
   end
   assign neuron_done = (k == IS + 2);

   int n_chk = 0;
   int n_fail = 0;

   // Per-run observations
   int               wr_n, start_n, done_n, done_c;
   int               wr_c [8];
   logic [IDX_W-1:0] wr_a [8];
   data_t            wr_d [8];
   int               st_c [8];
   logic             busy_at [128];
   logic             err_at [128];
   logic [IDX_W-1:0] am_done, am_end;
   logic             amv_done;

   task automatic run_layer(input bit hold, input int ncyc);
      @(negedge clk);
      layer_start = 1'b1;
      wr_n = 0; start_n = 0; done_n = 0; done_c = -1;
      am_done = '0; amv_done = 1'b0;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         if (!hold) layer_start = 1'b0;
         busy_at[c] = layer_busy;
         err_at[c]  = timeout_err;
         if (neuron_start && start_n < 8) begin st_c[start_n] = c; start_n++; end
         if (out_wr_en && wr_n < 8) begin
            wr_c[wr_n] = c; wr_a[wr_n] = out_wr_addr; wr_d[wr_n] = out_wr_data; wr_n++;
         end
         if (layer_done) begin
            done_n++;
            if (done_c < 0) begin done_c = c; am_done = argmax_s; amv_done = argmax_valid_s; end
         end
         am_end = argmax_s;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_chk++; if (layer_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", layer_busy); end
      n_chk++; if (layer_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", layer_done); end
      n_chk++; if (neuron_start !== 1'b0) begin n_fail++; $display("FAIL reset_nstart got=%b exp=0", neuron_start); end
      n_chk++; if (neuron_sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel got=%0d exp=0", neuron_sel); end
      n_chk++; if (out_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got=%b exp=0", out_wr_en); end
      n_chk++; if (out_wr_data !== 16'sd0) begin n_fail++; $display("FAIL reset_wr_data got=%0d exp=0", out_wr_data); end
      n_chk++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_terr got=%b exp=0", timeout_err); end
`ifdef SEQ_ARGMAX_EN
      n_chk++; if (argmax !== 2'd0) begin n_fail++; $display("FAIL reset_argmax got=%0d exp=0", argmax); end
      n_chk++; if (argmax_valid !== 1'b0) begin n_fail++; $display("FAIL reset_amv got=%b exp=0", argmax_valid); end
`endif
   endtask

   task automatic test_normal;
      data_t exp_d [NN];
      exp_d[0] = 16'sd5; exp_d[1] = 16'sd12; exp_d[2] = 16'sd7;
      for (int i = 0; i < NN; i++) res[i] = exp_d[i];
      stub = 1'b0;
      run_layer(1'b0, 32);
      n_chk++; if (wr_n !== NN) begin n_fail++; $display("FAIL normal_wr_count got=%0d exp=%0d", wr_n, NN); end
      for (int i = 0; i < NN && i < wr_n; i++) begin
         n_chk++; if (wr_c[i] !== 1 + i*P + IS + 3) begin n_fail++; $display("FAIL normal_wr_cycle[%0d] got=%0d exp=%0d", i, wr_c[i], 1 + i*P + IS + 3); end
         n_chk++; if (wr_a[i] !== IDX_W'(i)) begin n_fail++; $display("FAIL normal_wr_addr[%0d] got=%0d exp=%0d", i, wr_a[i], i); end
         n_chk++; if (wr_d[i] !== exp_d[i]) begin n_fail++; $display("FAIL normal_wr_data[%0d] got=%0d exp=%0d", i, wr_d[i], exp_d[i]); end
      end
      n_chk++; if (done_c !== 28) begin n_fail++; $display("FAIL normal_done_cycle got=%0d exp=28", done_c); end
      n_chk++; if (done_n !== 1) begin n_fail++; $display("FAIL normal_done_count got=%0d exp=1", done_n); end
      n_chk++; if (start_n !== NN) begin n_fail++; $display("FAIL normal_start_count got=%0d exp=%0d", start_n, NN); end
      n_chk++; if (st_c[1] !== 1 + P) begin n_fail++; $display("FAIL normal_start1_cycle got=%0d exp=%0d", st_c[1], 1 + P); end
      n_chk++; if (busy_at[1] !== 1'b1) begin n_fail++; $display("FAIL normal_busy_c1 got=%b exp=1", busy_at[1]); end
      n_chk++; if (busy_at[29] !== 1'b0) begin n_fail++; $display("FAIL normal_busy_c29 got=%b exp=0", busy_at[29]); end
      n_chk++; if (err_at[32] !== 1'b0) begin n_fail++; $display("FAIL normal_terr got=%b exp=0", err_at[32]); end
`ifdef SEQ_ARGMAX_EN
      n_chk++; if (am_done !== 2'd1) begin n_fail++; $display("FAIL normal_argmax got=%0d exp=1", am_done); end
      n_chk++; if (amv_done !== 1'b1) begin n_fail++; $display("FAIL normal_amv got=%b exp=1", amv_done); end
      n_chk++; if (am_end !== 2'd1) begin n_fail++; $display("FAIL normal_argmax_hold got=%0d exp=1", am_end); end
`endif
   endtask

   task automatic test_zero_results;
      for (int i = 0; i < NN; i++) res[i] = 16'sd0;
      run_layer(1'b0, 30);
      n_chk++; if (done_c !== 28) begin n_fail++; $display("FAIL zero_done_cycle got=%0d exp=28", done_c); end
      n_chk++; if (wr_d[1] !== 16'sd0) begin n_fail++; $display("FAIL zero_wr_data got=%0d exp=0", wr_d[1]); end
`ifdef SEQ_ARGMAX_EN
      n_chk++; if (am_done !== 2'd0) begin n_fail++; $display("FAIL zero_argmax got=%0d exp=0", am_done); end
`endif
   endtask

   task automatic test_timeout;
      for (int i = 0; i < NN; i++) res[i] = 16'sd100;
      stub = 1'b1;
      run_layer(1'b0, 70);
      n_chk++; if (wr_n !== NN) begin n_fail++; $display("FAIL to_wr_count got=%0d exp=%0d", wr_n, NN); end
      for (int i = 0; i < NN && i < wr_n; i++) begin
         n_chk++; if (wr_c[i] !== 1 + TO + i*(TO + 2)) begin n_fail++; $display("FAIL to_wr_cycle[%0d] got=%0d exp=%0d", i, wr_c[i], 1 + TO + i*(TO + 2)); end
         n_chk++; if (wr_d[i] !== 16'sd0) begin n_fail++; $display("FAIL to_wr_data[%0d] got=%0d exp=0", i, wr_d[i]); end
         n_chk++; if (wr_a[i] !== IDX_W'(i)) begin n_fail++; $display("FAIL to_wr_addr[%0d] got=%0d exp=%0d", i, wr_a[i], i); end
      end
      n_chk++; if (err_at[21] !== 1'b0) begin n_fail++; $display("FAIL to_terr_c21 got=%b exp=0", err_at[21]); end
      n_chk++; if (err_at[22] !== 1'b1) begin n_fail++; $display("FAIL to_terr_c22 got=%b exp=1", err_at[22]); end
      n_chk++; if (err_at[70] !== 1'b1) begin n_fail++; $display("FAIL to_terr_sticky got=%b exp=1", err_at[70]); end
      n_chk++; if (done_c !== 67) begin n_fail++; $display("FAIL to_done_cycle got=%0d exp=67", done_c); end
`ifdef SEQ_ARGMAX_EN
      n_chk++; if (am_done !== 2'd0) begin n_fail++; $display("FAIL to_argmax got=%0d exp=0", am_done); end
`endif
      stub = 1'b0;
   endtask

   task automatic test_hold_start_and_reset;
      int ns, nw, nb;
      res[0] = 16'sd9; res[1] = 16'sd9; res[2] = 16'sd3;
      run_layer(1'b1, 41);
      layer_start = 1'b0;
      n_chk++; if (err_at[1] !== 1'b0) begin n_fail++; $display("FAIL hold_terr_cleared got=%b exp=0", err_at[1]); end
      n_chk++; if (done_c !== 28 || done_n !== 1) begin n_fail++; $display("FAIL hold_done got=c%0d/n%0d exp=c28/n1", done_c, done_n); end
      n_chk++; if (start_n !== NN + 2) begin n_fail++; $display("FAIL hold_start_count got=%0d exp=%0d", start_n, NN + 2); end
      n_chk++; if (busy_at[29] !== 1'b0) begin n_fail++; $display("FAIL hold_idle_c29 got=%b exp=0", busy_at[29]); end
      n_chk++; if (st_c[3] !== 30) begin n_fail++; $display("FAIL hold_restart_cycle got=%0d exp=30", st_c[3]); end
`ifdef SEQ_ARGMAX_EN
      n_chk++; if (am_done !== 2'd0) begin n_fail++; $display("FAIL tie_argmax got=%0d exp=0", am_done); end
`endif
      n_chk++; if (neuron_sel !== 2'd1) begin n_fail++; $display("FAIL prerst_sel got=%0d exp=1", neuron_sel); end
      // Cycle 41 is WAIT of neuron 1 in the second run
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_chk++; if (layer_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", layer_busy); end
      n_chk++; if (neuron_sel !== 2'd0) begin n_fail++; $display("FAIL rst_sel got=%0d exp=0", neuron_sel); end
      n_chk++; if (out_wr_en !== 1'b0 || neuron_start !== 1'b0 || layer_done !== 1'b0) begin n_fail++; $display("FAIL rst_strobes got=%b%b%b exp=000", out_wr_en, neuron_start, layer_done); end
      ns = 0; nw = 0; nb = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (neuron_start) ns++;
         if (out_wr_en) nw++;
         if (layer_busy || layer_done) nb++;
      end
      n_chk++; if (ns !== 0) begin n_fail++; $display("FAIL postrst_starts got=%0d exp=0", ns); end
      n_chk++; if (nw !== 0) begin n_fail++; $display("FAIL postrst_writes got=%0d exp=0", nw); end
      n_chk++; if (nb !== 0) begin n_fail++; $display("FAIL postrst_busy got=%0d exp=0", nb); end
   endtask

   initial begin
      for (int i = 0; i < NN; i++) res[i] = '0;
      test_reset();
      test_normal();
      test_zero_results();
      test_timeout();
      test_hold_start_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Initiator-side controller for the neuron MAC engine. It walks a dense layer one neuron at a time, driving the neuron-select index and `neuron_start`, waiting for `neuron_done`, and capturing each ReLU/saturated result into an output buffer. It sits between the network top-level FSM and the neuron instance plus its weight/bias mux. It reports layer completion and, optionally, the index of the largest result.

## Interface
- `NUM_NEURONS`, default 10: neurons in the layer.
- `INPUT_SIZE`, default 784: MAC length of the attached neuron; used only for the latency contract.
- `TIMEOUT`, default `INPUT_SIZE+16`: maximum WAIT cycles before a neuron is declared hung.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `layer_start`, in, 1: request to run the layer; sampled only in IDLE.
- `layer_busy`, out, 1: high in every state except IDLE.
- `layer_done`, out, 1: one-cycle pulse in the DONE state.
- `neuron_sel`, out, `$clog2(NUM_NEURONS)`: current neuron index; drives the external weight/bias mux.
- `neuron_start`, out, 1: one-cycle pulse to the neuron.
- `neuron_done`, in, 1: one-cycle done pulse from the neuron.
- `neuron_result`, in, signed 16: neuron output; valid the cycle after `neuron_done`.
- `out_wr_en`, out, 1: output-buffer write strobe.
- `out_wr_addr`, out, `$clog2(NUM_NEURONS)`: write address; equals `neuron_sel`.
- `out_wr_data`, out, signed 16: write data.
- `timeout_err`, out, 1: sticky; cleared on an accepted `layer_start`.
- `argmax`, out, `$clog2(NUM_NEURONS)`: present only with the macro enabled.
- `argmax_valid`, out, 1: present only with the macro enabled.

## Operation
- Reset values: every output 0; state IDLE; index 0; watchdog 0.
- IDLE: when `layer_start`=1, set index to 0, clear `timeout_err`, clear argmax tracking, and go to START.
- START: assert `neuron_start` for exactly one cycle, clear the watchdog, go to WAIT.
- WAIT: if `neuron_done`=1, go to CAPTURE. Otherwise increment the watchdog. When the watchdog reaches `TIMEOUT-1`:
  - set `timeout_err`,
  - write 0 to the slot (`out_wr_en`=1, data 0),
  - go to NEXT.
- CAPTURE: `out_wr_en`=1, `out_wr_data`=`neuron_result`, `out_wr_addr`=index. Update argmax. Go to NEXT.
- NEXT: if index equals `NUM_NEURONS-1`, go to DONE; otherwise increment index and go to START.
- DONE: `layer_done`=1 (and `argmax_valid`=1 with the macro enabled), then go to IDLE.
- `layer_start` outside IDLE is ignored, including in the DONE cycle.
- `neuron_done` outside WAIT is ignored.
- `neuron_sel` holds its value from START through NEXT for each neuron; the weights it selects stay stable for the whole MAC.
- Reset mid-operation: state goes to IDLE the next cycle and all outputs return to 0. There is no partial `layer_done`. The sequencer does not reset the neuron.

## Timing
- Neuron contract, counting the `neuron_start` cycle as cycle 0:
  - `neuron_done` is high in cycle `INPUT_SIZE+2`,
  - `neuron_result` is valid from cycle `INPUT_SIZE+3`.
- Per-neuron period P = `INPUT_SIZE+5`, measured START to START: CAPTURE falls at +`INPUT_SIZE+3`, NEXT at +`INPUT_SIZE+4`.
- With `layer_start` sampled in cycle 0, the first START is in cycle 1 and `layer_done` is in cycle `NUM_NEURONS*P+1`. Defaults give 7891.
- A timed-out neuron occupies `TIMEOUT` WAIT cycles, then NEXT.
- Output-buffer writes are single-cycle and land at cycle offsets 1+k*P+`INPUT_SIZE+3`.

## Configuration
- `SEQ_ARGMAX_EN` defined:
  - Track the running maximum of written data and its index.
  - Update only on a strictly greater value, so ties keep the lowest index.
  - Initial max is -32768. A timed-out slot contributes 0.
  - `argmax` holds its value from DONE until the next accepted `layer_start`.
- `SEQ_ARGMAX_EN` undefined: `argmax` and `argmax_valid` ports and all tracking logic are absent. All other timing is identical.

## Structure
- Shared package `nn_pkg` holds:
  - `DATA_W`=16,
  - typedef `data_t` (signed `[DATA_W-1:0]`),
  - enum `seq_state_e` {IDLE, START, WAIT, CAPTURE, NEXT, DONE}.
- One sub-module, `argmax_tracker`, instantiated only under `SEQ_ARGMAX_EN`. Inputs: clear, write strobe, index, data. Outputs: argmax index.

## Test plan
- Real neuron, `INPUT_SIZE`=4, `NUM_NEURONS`=3, results 5, 12, 7 -> writes (0,5), (1,12), (2,7) at cycles 8, 17, 26; `layer_done` in cycle 28; `argmax`=1; `timeout_err`=0.
- Stub neuron never asserts done, `TIMEOUT`=20, `NUM_NEURONS`=2 -> each slot written with 0 after 20 WAIT cycles; `timeout_err`=1; `layer_done` still pulses; next `layer_start` clears `timeout_err`.
- `layer_start` held high throughout -> exactly one `neuron_start` per neuron; start during DONE ignored; new run begins only from IDLE.
- `rst`=1 during WAIT of neuron 1 -> next cycle all outputs 0 and `layer_busy`=0; no `neuron_start` until a new `layer_start`.
- With `SEQ_ARGMAX_EN`, results 9, 9, 3 -> `argmax`=0; results all 0 -> `argmax`=0.
- Without `SEQ_ARGMAX_EN` -> compiles with no argmax ports; write and `layer_done` cycles match scenario 1.
